// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order instruction-bus reads and
// buffers returned words in a small FIFO presented one per cycle to if_id.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_jump_flag_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        hold_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q;
  logic [CW-1:0] out_q, disc_q, cnt_q, disc_jump;
  logic [AW-1:0] wr_q, rd_q, aw_q, ar_q;
  logic [31:0]   data_mem  [FIFO_DEPTH];
  logic [31:0]   iaddr_mem [FIFO_DEPTH];
  logic [31:0]   raddr_mem [FIFO_DEPTH];
  logic          hs, push, pop;

  assign hs        = ibus_req_o & ibus_gnt_i;
  assign push      = ibus_rvalid_i & (disc_q == '0) & ~ex_jump_flag_i;
  assign pop       = (cnt_q != '0) & ~hold_i & ~ex_jump_flag_i;
  // A response arriving in the jump cycle is already stale and counts against discard.
  assign disc_jump = out_q - CW'(ibus_rvalid_i);

  always_comb begin
    state_d    = state_q;
    ibus_req_o = (state_q == ST_FETCH) & ~ex_jump_flag_i &
                 (({1'b0, cnt_q} + {1'b0, out_q}) < DEPTH_C);
    unique case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: if (ex_jump_flag_i && disc_jump != '0) state_d = ST_DRAIN;
      ST_DRAIN: if (!ex_jump_flag_i && disc_q == '0) state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      aw_q    <= '0;
      ar_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ex_jump_flag_i) begin
        pc_q   <= ex_jump_addr_i & ~32'h3;
        out_q  <= disc_jump;
        disc_q <= disc_jump;
        cnt_q  <= '0;
        wr_q   <= '0;
        rd_q   <= '0;
        ar_q   <= aw_q;
      end else begin
        if (hs) begin
          pc_q <= pc_q + 32'd4;
          aw_q <= aw_q + AW'(1);
        end
        out_q <= out_q + CW'(hs) - CW'(ibus_rvalid_i);
        if (ibus_rvalid_i && disc_q != '0) disc_q <= disc_q - CW'(1);
        if (push) begin
          wr_q <= wr_q + AW'(1);
          ar_q <= ar_q + AW'(1);
        end
        if (pop) rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Request addresses are captured at grant and paired with their data on return.
  always_ff @(posedge clk) begin
    if (hs) raddr_mem[aw_q] <= pc_q;
    if (push) begin
      data_mem[wr_q]  <= ibus_rdata_i;
      iaddr_mem[wr_q] <= raddr_mem[ar_q];
    end
  end

  assign ibus_addr_o  = pc_q;
  assign inst_valid_o = (cnt_q != '0);
  assign inst_o       = inst_valid_o ? data_mem[rd_q]  : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? iaddr_mem[rd_q] : '0;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(ibus_rvalid_i && out_q == '0));
  a_budget: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, cnt_q} + {1'b0, out_q}) <= DEPTH_C));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: queue-based reference model, in-order bus memory,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ifu_fetch;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_jump_flag_i = 1'b0;
  logic [31:0] ex_jump_addr_i = '0;
  logic        hold_i = 1'b0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = '0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  ifu_fetch #(.RESET_PC(32'h0), .NOP_INST(NOP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_jump_flag_i(ex_jump_flag_i), .ex_jump_addr_i(ex_jump_addr_i),
    .hold_i(hold_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // reference model state
  bit          m_boot, m_drain;
  logic [31:0] m_pc;
  int          m_out, m_disc;
  logic [31:0] m_live[$];
  logic [31:0] m_fifo[$];
  // bus memory: granted addresses awaiting a response
  logic [31:0] mem_q[$];
  // DUT values sampled in the latest step
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_iaddr, s_inst;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(ibus_req_o),   32'h0);
    chk({tag, "_addr"},  ibus_addr_o,       32'h0);
    chk({tag, "_inst"},  inst_o,            32'h0000_0013);
    chk({tag, "_iaddr"}, inst_addr_o,       32'h0);
    chk({tag, "_valid"}, 32'(inst_valid_o), 32'h0);
  endtask

  // Hold reset over two edges, check reset outputs, release at a negedge.
  task automatic do_reset();
    rst = 1'b1;
    ex_jump_flag_i = 1'b0; hold_i = 1'b0; ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0;
    mem_q.delete(); m_live.delete(); m_fifo.delete();
    m_boot = 1; m_drain = 0; m_pc = '0; m_out = 0; m_disc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
  endtask

  // One cycle: drive at negedge, compare at +1, advance model and memory at posedge.
  task automatic step(input bit j, input logic [31:0] ja, input bit h, input bit g, input bit rv_en);
    bit e_req, e_v, rv, pop, leave, dut_hs;
    logic [31:0] dut_a;
    rv = rv_en && (mem_q.size() != 0);
    ex_jump_flag_i = j;
    ex_jump_addr_i = ja;
    hold_i         = h;
    ibus_gnt_i     = g;
    ibus_rvalid_i  = rv;
    ibus_rdata_i   = rv ? f(mem_q[0]) : $urandom;
    #1;
    e_req = !m_boot && !m_drain && !j && ((m_fifo.size() + m_out) < DEPTH);
    e_v   = m_fifo.size() != 0;
    chk("req",   32'(ibus_req_o),   32'(e_req));
    chk("addr",  ibus_addr_o,       m_pc);
    chk("valid", 32'(inst_valid_o), 32'(e_v));
    chk("inst",  inst_o,            e_v ? f(m_fifo[0]) : NOP);
    chk("iaddr", inst_addr_o,       e_v ? m_fifo[0] : 32'h0);
    s_req = ibus_req_o; s_addr = ibus_addr_o; s_valid = inst_valid_o;
    s_iaddr = inst_addr_o; s_inst = inst_o;
    dut_hs = ibus_req_o && g;
    dut_a  = ibus_addr_o;
    @(posedge clk);
    if (rv) void'(mem_q.pop_front());
    if (dut_hs) mem_q.push_back(dut_a);
    if (m_boot) begin
      m_boot = 0;
    end else if (j) begin
      if (rv) m_out--;
      m_disc = m_out;
      m_live.delete();
      m_fifo.delete();
      m_pc = {ja[31:2], 2'b00};
      if (!m_drain) m_drain = (m_disc > 0);
    end else begin
      pop   = (m_fifo.size() != 0) && !h;
      leave = m_drain && (m_disc == 0);
      if (pop) void'(m_fifo.pop_front());
      if (rv) begin
        m_out--;
        if (m_disc > 0) m_disc--;
        else if (m_live.size() != 0) m_fifo.push_back(m_live.pop_front());
      end
      if (e_req && g) begin
        m_live.push_back(m_pc);
        m_pc += 32'd4;
        m_out++;
      end
      if (leave) m_drain = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, req_seen;
    int pj, ph, pg, prv;
    logic [31:0] ja;

    // 1-cycle memory: boot cycle, first request to 0, stream 0,4,8...
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(0, '0, 0, 1, 1);
      if (i == 0) chk("t1_boot_req", 32'(s_req), 32'h0);
      if (i == 1) begin
        chk("t1_first_req", 32'(s_req), 32'h1);
        chk("t1_first_addr", s_addr, 32'h0);
      end
      if (i == 3) begin
        chk("t1_first_iaddr", s_iaddr, 32'h0);
        chk("t1_first_inst", s_inst, 32'hDEAD_0000);
      end
      if (i == 4) chk("t1_second_iaddr", s_iaddr, 32'h4);
    end
    // hold for 6 cycles: request throttles, nothing lost
    for (int i = 0; i < 6; i++) step(0, '0, 1, 1, 1);
    chk("t2_hold_req_low", 32'(s_req), 32'h0);
    for (int i = 0; i < 8; i++) step(0, '0, 0, 1, 1);

    // grant withheld three cycles while addr 8 is requested
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 0, !(i >= 4 && i <= 6), 1);
      if (i == 6) begin
        chk("t3_wait_req", 32'(s_req), 32'h1);
        chk("t3_wait_addr", s_addr, 32'h8);
      end
      if (i == 8) chk("t3_resume_addr", s_addr, 32'hC);
    end

    // jump to 0x100 with two outstanding requests
    do_reset();
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 0);
    chk("t4_out2_req", 32'(s_req), 32'h0);
    step(1, 32'h100, 0, 1, 0);
    chk("t4_jump_req", 32'(s_req), 32'h0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, '0, 0, 1, 1);
      if (s_valid) begin
        found = 1;
        chk("t4_first_iaddr", s_iaddr, 32'h100);
        chk("t4_first_inst", s_inst, 32'hDEAD_0100);
      end
    end
    chk("t4_valid_seen", 32'(found), 32'h1);

    // jump to 0x102 coincident with rvalid and hold
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 0);
    step(1, 32'h102, 1, 1, 1);
    chk("t5_jump_req", 32'(s_req), 32'h0);
    step(0, '0, 0, 1, 1);
    chk("t5_fifo_cleared", 32'(s_valid), 32'h0);
    found = 0; req_seen = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, '0, 0, 1, 1);
      if (s_req && !req_seen) begin
        req_seen = 1;
        chk("t5_req_addr", s_addr, 32'h100);
      end
      if (s_valid) begin
        found = 1;
        chk("t5_first_iaddr", s_iaddr, 32'h100);
      end
    end
    chk("t5_valid_seen", 32'(found), 32'h1);

    // randomized traffic, with asynchronous resets mid-stream
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      pj  = $urandom_range(2, 10);
      ph  = $urandom_range(0, 60);
      pg  = $urandom_range(30, 100);
      prv = $urandom_range(30, 100);
      for (int i = 0; i < 500; i++) begin
        ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        step(!m_boot && ($urandom_range(0, 99) < pj), ja,
             $urandom_range(0, 99) < ph, $urandom_range(0, 99) < pg,
             $urandom_range(0, 99) < prv);
      end
      if (blk == 2 || blk == 4) begin
        #3 rst = 1'b1;
        #1 chk_reset_outputs("async_rst");
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
